// File: rtl/stage_id_decode.sv
// stage_id_decode: RV32I instruction-decode stage.
// Slices register indices and builds the sign-extended immediate combinationally,
// then captures operands, immediate and decode fields into the ID/EX register.
// Optional feature macro: STAGE_ID_WB_BYPASS_EN -- forwards the write-back result
// into the captured operands when it targets rs1/rs2 in the same cycle.
module stage_id_decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] reg_data1,
    input  logic [XLEN-1:0] reg_data2,
`ifdef STAGE_ID_WB_BYPASS_EN
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
`endif
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7
);

    // RV32I major opcodes that carry an immediate
    typedef enum logic [6:0] {
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_JALR   = 7'b1100111,
        OP_SYSTEM = 7'b1110011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    // Register indices are raw field slices regardless of format
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];
    assign imm = w_imm;

    // Immediate generation by instruction format; R-type and unknown opcodes give zero
    always_comb begin
        // NOTE: default first so every path assigns w_imm and no latch is inferred.
        w_imm = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                w_imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                w_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                w_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {instr[31:12], 12'b0};
            OP_JAL:
                w_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                w_imm = '0;
        endcase
    end

    // Operand selection: register-file data, optionally overridden by the write-back value
    always_comb begin
        w_op1 = reg_data1;
        w_op2 = reg_data2;
`ifdef STAGE_ID_WB_BYPASS_EN
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1)) w_op1 = wb_data;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2)) w_op2 = wb_data;
`endif
    end

    // ID/EX register: reset > flush (bubble) > stall (hold) > load
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n || flush) begin
            ex_valid    <= 1'b0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
        end else if (!stall) begin
            ex_valid    <= 1'b1;
            ex_rs1_data <= w_op1;
            ex_rs2_data <= w_op2;
            ex_imm      <= w_imm;
            ex_rd       <= rd;
            ex_opcode   <= instr[6:0];
            ex_funct3   <= instr[14:12];
            ex_funct7   <= instr[31:25];
        end
    end

endmodule

// File: tb/tb_stage_id_decode.sv
// tb_stage_id_decode: directed self-checking bench for stage_id_decode.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_stage_id_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] reg_data1;
    logic [31:0] reg_data2;
`ifdef STAGE_ID_WB_BYPASS_EN
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`endif
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ex_valid;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;

    int checks = 0;
    int errors = 0;

    stage_id_decode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .instr       (instr),
        .reg_data1   (reg_data1),
        .reg_data2   (reg_data2),
`ifdef STAGE_ID_WB_BYPASS_EN
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
`endif
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .ex_valid    (ex_valid),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_rd       (ex_rd),
        .ex_opcode   (ex_opcode),
        .ex_funct3   (ex_funct3),
        .ex_funct7   (ex_funct7)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Combinational immediate vectors with hand-computed results
    logic [31:0] imm_instr [8];
    logic [31:0] imm_exp   [8];

    initial begin
        imm_instr[0] = 32'hFFF00093; imm_exp[0] = 32'hFFFFFFFF; // addi -1
        imm_instr[1] = 32'h123452B7; imm_exp[1] = 32'h12345000; // lui
        imm_instr[2] = 32'hFE000EE3; imm_exp[2] = 32'hFFFFFFFC; // beq -4
        imm_instr[3] = 32'h0000006F; imm_exp[3] = 32'h00000000; // jal 0
        imm_instr[4] = 32'h008000EF; imm_exp[4] = 32'h00000008; // jal x1,8
        imm_instr[5] = 32'hFE112E23; imm_exp[5] = 32'hFFFFFFFC; // sw -4
        imm_instr[6] = 32'h00001017; imm_exp[6] = 32'h00001000; // auipc
        imm_instr[7] = 32'h40208033; imm_exp[7] = 32'h00000000; // sub (R-type)

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        instr = 32'h00208093; reg_data1 = 32'h0; reg_data2 = 32'h0;
`ifdef STAGE_ID_WB_BYPASS_EN
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
`endif
        step();
        step();
        check("rst_ex_valid",   {31'b0, ex_valid}, 32'h0);
        check("rst_ex_rs1",     ex_rs1_data,       32'h0);
        check("rst_ex_imm",     ex_imm,            32'h0);
        check("rst_ex_opcode",  {25'b0, ex_opcode}, 32'h0);
        check("rst_ex_rd",      {27'b0, ex_rd},    32'h0);
        check("rst_comb_rs1",   {27'b0, rs1},      32'd1);
        check("rst_comb_imm",   imm,               32'h2);

        // addi x1,x1,2
        rst_n = 1'b1; reg_data1 = 32'h11111111; reg_data2 = 32'hAAAA0002;
        #1;
        check("addi_rs1", {27'b0, rs1}, 32'd1);
        check("addi_rs2", {27'b0, rs2}, 32'd2);
        check("addi_rd",  {27'b0, rd},  32'd1);
        check("addi_imm", imm,          32'h2);
        step();
        check("addi_ex_valid",  {31'b0, ex_valid},  32'h1);
        check("addi_ex_rs1",    ex_rs1_data,        32'h11111111);
        check("addi_ex_rs2",    ex_rs2_data,        32'hAAAA0002);
        check("addi_ex_imm",    ex_imm,             32'h2);
        check("addi_ex_rd",     {27'b0, ex_rd},     32'd1);
        check("addi_ex_opcode", {25'b0, ex_opcode}, 32'h13);
        check("addi_ex_funct3", {29'b0, ex_funct3}, 32'h0);

        // sw x4,2(x2)
        instr = 32'h00412123; reg_data1 = 32'h22222222;
        #1;
        check("sw_rs1", {27'b0, rs1}, 32'd2);
        check("sw_rs2", {27'b0, rs2}, 32'd4);
        check("sw_imm", imm,          32'h2);
        step();
        check("sw_ex_rs1",    ex_rs1_data,        32'h22222222);
        check("sw_ex_opcode", {25'b0, ex_opcode}, 32'h23);
        check("sw_ex_funct3", {29'b0, ex_funct3}, 32'h2);
        check("sw_ex_imm",    ex_imm,             32'h2);

        // Immediate formats, combinational only
        for (int k = 0; k < 8; k++) begin
            instr = imm_instr[k];
            #1;
            check($sformatf("imm_vec%0d", k), imm, imm_exp[k]);
        end

        // sub x0,x1,x2: R-type, funct7 = 0100000
        instr = 32'h40208033; reg_data1 = 32'h33333333; reg_data2 = 32'h44444444;
        step();
        check("sub_ex_valid",  {31'b0, ex_valid},  32'h1);
        check("sub_ex_imm",    ex_imm,             32'h0);
        check("sub_ex_funct7", {25'b0, ex_funct7}, 32'h20);
        check("sub_ex_opcode", {25'b0, ex_opcode}, 32'h33);

        // Stall holds everything
        stall = 1'b1; instr = 32'hFFF00093; reg_data1 = 32'h55555555;
        step();
        check("stall_ex_valid",  {31'b0, ex_valid},  32'h1);
        check("stall_ex_rs1",    ex_rs1_data,        32'h33333333);
        check("stall_ex_rs2",    ex_rs2_data,        32'h44444444);
        check("stall_ex_funct7", {25'b0, ex_funct7}, 32'h20);
        check("stall_ex_opcode", {25'b0, ex_opcode}, 32'h33);

        // Stall and flush together: flush wins
        flush = 1'b1;
        step();
        check("sflush_ex_valid",  {31'b0, ex_valid},  32'h0);
        check("sflush_ex_rs1",    ex_rs1_data,        32'h0);
        check("sflush_ex_opcode", {25'b0, ex_opcode}, 32'h0);
        check("sflush_ex_funct7", {25'b0, ex_funct7}, 32'h0);

        // Resume with lui x5,0x12345
        stall = 1'b0; flush = 1'b0; instr = 32'h123452B7;
        step();
        check("lui_ex_valid", {31'b0, ex_valid}, 32'h1);
        check("lui_ex_imm",   ex_imm,            32'h12345000);
        check("lui_ex_rd",    {27'b0, ex_rd},    32'd5);
        check("lui_ex_rs1",   ex_rs1_data,       32'h55555555);

        // Flush alone
        flush = 1'b1;
        step();
        check("flush_ex_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_ex_imm",   ex_imm,            32'h0);
        flush = 1'b0; instr = 32'h008000EF;
        step();
        check("jal_ex_valid", {31'b0, ex_valid}, 32'h1);
        check("jal_ex_imm",   ex_imm,            32'h8);

        // Reset mid-stream discards the entry; load resumes on the first edge after release
        rst_n = 1'b0;
        step();
        check("mrst_ex_valid", {31'b0, ex_valid}, 32'h0);
        check("mrst_ex_imm",   ex_imm,            32'h0);
        rst_n = 1'b1;
        step();
        check("mrst_rel_valid", {31'b0, ex_valid}, 32'h1);
        check("mrst_rel_imm",   ex_imm,            32'h8);

`ifdef STAGE_ID_WB_BYPASS_EN
        // Write-back forwarding into rs1, then rs2, then x0 and we=0 cases
        instr = 32'h00208093; reg_data1 = 32'h11111111; reg_data2 = 32'h22222222;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
        step();
        check("byp_rs1", ex_rs1_data, 32'hDEADBEEF);
        check("byp_rs1_other", ex_rs2_data, 32'h22222222);
        wb_rd = 5'd2;
        step();
        check("byp_rs2", ex_rs2_data, 32'hDEADBEEF);
        check("byp_rs2_other", ex_rs1_data, 32'h11111111);
        instr = 32'h00000013; wb_rd = 5'd0;
        step();
        check("byp_x0", ex_rs1_data, 32'h11111111);
        instr = 32'h00208093; wb_we = 1'b0; wb_rd = 5'd1;
        step();
        check("byp_we0", ex_rs1_data, 32'h11111111);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
